// File: rtl/bcd_key_counter.sv
// bcd_key_counter
//   Front end of the two-digit display path. Conditions four raw active-low
//   push buttons (2-flop sync, debounce, press-edge detect, auto-repeat on
//   inc/dec) and keeps a two-digit BCD count 00..99.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   bt[3:0]     raw buttons, active-low: 0=inc 1=dec 2=clear 3=load
//   sw[3:0]     binary preset 0..15, taken on a load event
//   digit_hi    tens digit, BCD 0..9
//   digit_lo    ones digit, BCD 0..9
//   press_pulse one-cycle pulse per accepted press or repeat event, per button
//   wrap        one-cycle pulse alongside a 99->00 or 00->99 wrapped value
module bcd_key_counter #(
    parameter int unsigned DB_CYCLES     = 240000,
    parameter int unsigned REPEAT_DELAY  = 6000000,
    parameter int unsigned REPEAT_PERIOD = 1200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bt,
    input  logic [3:0] sw,
    output logic [3:0] digit_hi,
    output logic [3:0] digit_lo,
    output logic [3:0] press_pulse,
    output logic       wrap
);

    localparam int unsigned DBW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HW       = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    typedef enum logic {
        REP_DELAY,
        REP_PERIOD
    } rep_state_t;

    logic [3:0]     sync1;
    logic [3:0]     sync2;
    logic [3:0]     db;
    logic [3:0]     db_q;
    logic [DBW-1:0] db_cnt [4];

    rep_state_t     rep_state     [2];
    rep_state_t     rep_state_nxt [2];
    logic [HW-1:0]  hold_cnt      [2];
    logic [HW-1:0]  hold_cnt_nxt  [2];
    logic [1:0]     rep_fire;

    logic [3:0]     fall;
    logic [3:0]     hi_nxt;
    logic [3:0]     lo_nxt;
    logic           wrap_nxt;

    // Two-flop synchroniser; released (1) out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= bt;
            sync2 <= sync1;
        end
    end

    // Debounce: the level must differ for DB_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db   <= '1;
            db_q <= '1;
            for (int unsigned i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            db_q <= db;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
                        db[i]     <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DBW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign fall = db_q & ~db;

    // Auto-repeat for inc/dec. The hold counter starts at 0 in the cycle the
    // press edge is seen, so it equals REPEAT_DELAY exactly REPEAT_DELAY cycles
    // after the press event; after each repeat it restarts at 1 so the next
    // match at REPEAT_PERIOD is REPEAT_PERIOD cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                rep_state[i] <= REP_DELAY;
                hold_cnt[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                rep_state[i] <= rep_state_nxt[i];
                hold_cnt[i]  <= hold_cnt_nxt[i];
            end
        end
    end

    always_comb begin
        rep_fire = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            rep_state_nxt[i] = rep_state[i];
            hold_cnt_nxt[i]  = hold_cnt[i];
            if (db[i]) begin
                rep_state_nxt[i] = REP_DELAY;
                hold_cnt_nxt[i]  = '0;
            end else if ((rep_state[i] == REP_DELAY  && hold_cnt[i] == HW'(REPEAT_DELAY)) ||
                         (rep_state[i] == REP_PERIOD && hold_cnt[i] == HW'(REPEAT_PERIOD))) begin
                rep_fire[i]      = 1'b1;
                rep_state_nxt[i] = REP_PERIOD;
                hold_cnt_nxt[i]  = HW'(1);
            end else begin
                hold_cnt_nxt[i]  = hold_cnt[i] + HW'(1);
            end
        end
    end

    // Next count value; clear > load > inc/dec, with inc+dec cancelling.
    always_comb begin
        hi_nxt   = digit_hi;
        lo_nxt   = digit_lo;
        wrap_nxt = 1'b0;
        if (press_pulse[2]) begin
            hi_nxt = '0;
            lo_nxt = '0;
        end else if (press_pulse[3]) begin
            if (sw >= 4'd10) begin
                hi_nxt = 4'd1;
                lo_nxt = sw - 4'd10;
            end else begin
                hi_nxt = '0;
                lo_nxt = sw;
            end
        end else if (press_pulse[0] && !press_pulse[1]) begin
            if (digit_lo == 4'd9) begin
                lo_nxt = '0;
                if (digit_hi == 4'd9) begin
                    hi_nxt   = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    hi_nxt = digit_hi + 4'd1;
                end
            end else begin
                lo_nxt = digit_lo + 4'd1;
            end
        end else if (press_pulse[1] && !press_pulse[0]) begin
            if (digit_lo == 4'd0) begin
                lo_nxt = 4'd9;
                if (digit_hi == 4'd0) begin
                    hi_nxt   = 4'd9;
                    wrap_nxt = 1'b1;
                end else begin
                    hi_nxt = digit_hi - 4'd1;
                end
            end else begin
                lo_nxt = digit_lo - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_pulse <= '0;
            digit_hi    <= '0;
            digit_lo    <= '0;
            wrap        <= 1'b0;
        end else begin
            press_pulse <= fall | {2'b00, rep_fire};
            digit_hi    <= hi_nxt;
            digit_lo    <= lo_nxt;
            wrap        <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_key_counter.sv
// tb_bcd_key_counter
//   Directed bench for bcd_key_counter with short debounce/repeat timing.
//   Ports of the DUT are all driven/observed here; expected values are
//   hand-computed BCD constants and cycle offsets.
module tb_bcd_key_counter;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] bt    = 4'hF;
    logic [3:0] sw    = 4'h0;
    logic [3:0] digit_hi;
    logic [3:0] digit_lo;
    logic [3:0] press_pulse;
    logic       wrap;

    int checks   = 0;
    int failures = 0;

    int pulse_tot [4] = '{0, 0, 0, 0};
    int wrap_tot      = 0;

    typedef struct {
        logic [3:0] mask;     // buttons pressed together (1 = pressed)
        logic [3:0] swv;
        logic [7:0] exp_bcd;  // {tens, ones}
        int         exp_wrap;
    } vec_t;

    vec_t vecs [16];

    always #5 clk = ~clk;

    bcd_key_counter #(
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bt         (bt),
        .sw         (sw),
        .digit_hi   (digit_hi),
        .digit_lo   (digit_lo),
        .press_pulse(press_pulse),
        .wrap       (wrap)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (press_pulse[i]) pulse_tot[i]++;
            end
            if (wrap) wrap_tot++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [7:0] exp);
        check(name, {24'd0, digit_hi, digit_lo}, {24'd0, exp});
    endtask

    task automatic tap(input logic [3:0] mask);
        bt = ~mask;
        repeat (10) step();
        bt = 4'hF;
        repeat (10) step();
    endtask

    initial begin
        int n;
        int first;
        int wrap_k;
        int w0;
        int ts [8];
        int p0 [4];

        vecs[0]  = '{4'b1000, 4'd9,  8'h09, 0};
        vecs[1]  = '{4'b0001, 4'd0,  8'h10, 0};
        vecs[2]  = '{4'b0010, 4'd0,  8'h09, 0};
        vecs[3]  = '{4'b1000, 4'd13, 8'h13, 0};
        vecs[4]  = '{4'b1000, 4'd7,  8'h07, 0};
        vecs[5]  = '{4'b1000, 4'd15, 8'h15, 0};
        vecs[6]  = '{4'b0100, 4'd0,  8'h00, 0};
        vecs[7]  = '{4'b0010, 4'd0,  8'h99, 1};
        vecs[8]  = '{4'b0001, 4'd0,  8'h00, 1};
        vecs[9]  = '{4'b1000, 4'd10, 8'h10, 0};
        vecs[10] = '{4'b0010, 4'd0,  8'h09, 0};
        vecs[11] = '{4'b1100, 4'd5,  8'h00, 0};
        vecs[12] = '{4'b1000, 4'd12, 8'h12, 0};
        vecs[13] = '{4'b0011, 4'd0,  8'h12, 0};
        vecs[14] = '{4'b1000, 4'd0,  8'h00, 0};
        vecs[15] = '{4'b0001, 4'd0,  8'h01, 0};

        // Reset state
        repeat (3) step();
        check_val("reset_val", 8'h00);
        check("reset_pulse", {28'd0, press_pulse}, 32'd0);
        check("reset_wrap", {31'd0, wrap}, 32'd0);
        rst_n = 1'b1;
        repeat (3) step();
        check_val("post_reset_val", 8'h00);

        // Clean inc press: pulse after 2+DB+1 edges, digits one edge later.
        n = 0; first = 0; wrap_k = 0;
        bt = 4'b1110;
        for (int k = 1; k <= 22; k++) begin
            step();
            if (press_pulse[0]) begin
                n++;
                if (first == 0) first = k;
            end
            if (digit_lo == 4'd1 && wrap_k == 0) wrap_k = k;
            if (k == 10) bt = 4'hF;
        end
        check("t1_pulse_count", n, 1);
        check("t1_pulse_cycle", first, 7);
        check("t1_digit_cycle", wrap_k, 8);
        check_val("t1_val", 8'h01);

        // Bounce shorter than DB, then steady press: one increment only.
        n = 0;
        p0[0] = pulse_tot[0];
        bt = 4'b1110; repeat (2) step();
        bt = 4'b1111; repeat (2) step();
        bt = 4'b1110; repeat (2) step();
        bt = 4'b1111; repeat (2) step();
        repeat (2) step();
        check("t2_bounce_pulses", pulse_tot[0] - p0[0], 0);
        bt = 4'b1110; repeat (12) step();
        bt = 4'hF;    repeat (10) step();
        check("t2_total_pulses", pulse_tot[0] - p0[0], 1);
        check_val("t2_val", 8'h02);

        // Held inc from 00: press then repeats at +RD, +RP...; released between
        // the fifth and sixth event.
        tap(4'b0100);
        check_val("t3_clear", 8'h00);
        n = 0;
        for (int i = 0; i < 8; i++) ts[i] = 0;
        bt = 4'b1110;
        for (int k = 1; k <= 70; k++) begin
            step();
            if (press_pulse[0]) begin
                if (n < 8) ts[n] = k;
                n++;
            end
            if (k == 50) bt = 4'hF;
        end
        check("t3_inc_events", n, 5);
        check("t3_inc_first", ts[0], 7);
        check("t3_inc_delay", ts[1] - ts[0], RD);
        for (int i = 2; i < 5; i++) begin
            check($sformatf("t3_inc_period%0d", i), ts[i] - ts[i-1], RP);
        end
        check_val("t3_inc_val", 8'h05);

        // Held dec from 00: 99,98,97,96,95 with a single wrap on 00->99.
        tap(4'b0100);
        w0 = wrap_tot;
        n = 0; wrap_k = 0;
        bt = 4'b1101;
        for (int k = 1; k <= 70; k++) begin
            step();
            if (press_pulse[1]) n++;
            if (wrap && wrap_k == 0) wrap_k = k;
            if (k == 50) bt = 4'hF;
        end
        check("t3_dec_events", n, 5);
        check("t3_dec_wrap_cycle", wrap_k, 8);
        check("t3_dec_wraps", wrap_tot - w0, 1);
        check_val("t3_dec_val", 8'h95);

        // Table of single presses from the running value.
        for (int v = 0; v < 16; v++) begin
            sw = vecs[v].swv;
            for (int i = 0; i < 4; i++) p0[i] = pulse_tot[i];
            w0 = wrap_tot;
            tap(vecs[v].mask);
            check_val($sformatf("vec%0d_val", v), vecs[v].exp_bcd);
            check($sformatf("vec%0d_wrap", v), wrap_tot - w0, vecs[v].exp_wrap);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("vec%0d_pulse%0d", v, i), pulse_tot[i] - p0[i],
                      {31'd0, vecs[v].mask[i]});
            end
        end

        // Reset during auto-repeat with inc still held.
        bt = 4'b1110;
        repeat (30) step();
        check_val("t6_pre_reset_val", 8'h03);
        rst_n = 1'b0;
        #1;
        check_val("t6_async_val", 8'h00);
        check("t6_async_pulse", {28'd0, press_pulse}, 32'd0);
        repeat (3) step();
        check_val("t6_held_val", 8'h00);
        rst_n = 1'b1;
        n = 0; first = 0;
        for (int i = 0; i < 4; i++) p0[i] = pulse_tot[i];
        for (int k = 1; k <= 15; k++) begin
            step();
            if (press_pulse[0]) begin
                n++;
                if (first == 0) first = k;
            end
        end
        check("t6_pulse_count", n, 1);
        check("t6_pulse_cycle", first, 7);
        check("t6_other_pulses", (pulse_tot[1] - p0[1]) + (pulse_tot[2] - p0[2]) + (pulse_tot[3] - p0[3]), 0);
        check_val("t6_val", 8'h01);
        bt = 4'hF;
        repeat (10) step();
        check_val("t6_final_val", 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
